// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment receive path: active-low gfedcba
// patterns for the ten legal digits, the error digit and capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [3:0] INVALID_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decode; anything outside the ten
// legal glyphs maps to INVALID_DIGIT and raises illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       illegal
);

  always_comb begin
    digit   = INVALID_DIGIT;
    illegal = 1'b0;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_frame_capture.sv
// Collects NUM_DIGITS strobed segment patterns into a BCD frame (first digit
// in the top nibble) and holds it on a valid/ready handshake.
module seg7_frame_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic                    seg_valid,
  input  logic                    frame_start,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_bcd,
  output logic                    out_err,
  output logic [CNT_W-1:0]        digit_count,
  output logic                    busy
);

  localparam int W = 4 * NUM_DIGITS;

  state_t     state;
  logic [3:0] digit;
  logic       illegal;
  logic       last;

  seg7_pattern_decode u_decode (
    .pattern (seg_in),
    .digit   (digit),
    .illegal (illegal)
  );

  assign last = (digit_count == CNT_W'(NUM_DIGITS - 1));
  assign busy = (state == COLLECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_bcd     <= '0;
      out_err     <= 1'b0;
      digit_count <= '0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          // A coincident strobe becomes digit 1 of the restarted frame.
          if (frame_start) begin
            out_bcd     <= seg_valid ? W'(digit) : '0;
            out_err     <= seg_valid & illegal;
            digit_count <= seg_valid ? CNT_W'(1) : '0;
            if (seg_valid && NUM_DIGITS == 1) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end else if (state == COLLECT && seg_valid) begin
            out_bcd     <= (out_bcd << 4) | W'(digit);
            out_err     <= out_err | illegal;
            digit_count <= digit_count + CNT_W'(1);
            if (last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seg7_frame_capture.md
Name: seg7_frame_capture

Overview:
- Receive end of the seven-segment digit interface: samples active-low segment patterns (bit order gfedcba, bit 6 = g) presented one digit per strobe.
- Decodes each pattern back to a 4-bit BCD digit and assembles NUM_DIGITS digits into a frame.
- Presents the frame on a valid/ready output handshake.
- Used for display readback, self-check and loopback of the lab display path.

Parameters:
- NUM_DIGITS, 4, digits per frame (1..8).
- CNT_W, 3, width of digit_count; must satisfy 2^CNT_W > NUM_DIGITS.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  active-low segment pattern, gfedcba.
- seg_valid  in  1  one-cycle strobe; seg_in is sampled on this cycle.
- frame_start  in  1  one-cycle pulse; discards partial frame and begins a new one.
- out_ready  in  1  consumer accepts the frame.
- out_valid  out  1  frame complete and held.
- out_bcd  out  4*NUM_DIGITS  frame digits; first-received digit in the most significant nibble.
- out_err  out  1  at least one digit in the frame was an illegal pattern.
- digit_count  out  CNT_W  digits captured in the current frame.
- busy  out  1  high in COLLECT.

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid=0, out_bcd=0, out_err=0, digit_count=0, busy=0.
- Decode table, pattern -> digit:
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9
  - Any other pattern, including 0000001, -> 4'hF and sets the sticky frame error.
- States:
  - IDLE: seg_valid ignored. frame_start -> COLLECT with digit_count=0, out_bcd=0, out_err=0.
  - COLLECT: on each seg_valid, out_bcd <= {out_bcd[4*N-5:0], digit}, digit_count++, and out_err |= illegal. When the strobe captures digit NUM_DIGITS, go to HOLD; out_valid is asserted the following cycle (1-cycle latency from the last strobe).
  - HOLD: out_valid=1; out_bcd, out_err and digit_count are frozen. seg_valid and frame_start are ignored. out_valid&&out_ready -> IDLE next cycle, out_valid=0. out_bcd and out_err retain their values until the next frame_start.
- frame_start and seg_valid in the same cycle (IDLE or COLLECT): the frame restarts and that digit becomes digit 1 (digit_count=1, out_err reflects that digit only). With NUM_DIGITS=1 this goes directly to HOLD.
- frame_start in COLLECT alone: restart; the partial frame is lost, nothing is output.
- out_ready while not in HOLD: no effect.
- rst_n asserted in any state: immediate return to reset values; a partial or held frame is lost.
- busy = (state==COLLECT).

Decomposition:
- Package seg7_pkg holds:
  - the ten segment-pattern constants (SEG_0..SEG_9);
  - INVALID_DIGIT=4'hF;
  - the state encoding IDLE/COLLECT/HOLD.
- One combinational sub-module, seg7_pattern_decode: input 7-bit pattern; outputs 4-bit digit and illegal flag. It is instanced once inside seg7_frame_capture.

Test Plan:
1. frame_start, then seg_valid with 1111001, 0100100, 0110000, 0011001 on non-consecutive cycles, out_ready=1 -> out_valid for exactly one cycle, 1 cycle after the 4th strobe; out_bcd=16'h1234, out_err=0, then IDLE.
2. Frame 9,8,7,0 plus pattern 1111111 in place of 8, out_ready=0 for 5 cycles -> out_bcd=16'h9F70, out_err=1; out_valid held 5 cycles with stable data; extra seg_valid/frame_start during HOLD are ignored.
3. frame_start, 2 digits, frame_start again, then 5,6,6,5 -> out_bcd=16'h5665, out_err=0; first partial frame discarded.
4. frame_start coincident with seg_valid 0010010 in COLLECT, then 3 more digits 0 -> out_bcd=16'h5000, digit_count=4.
5. rst_n low mid-COLLECT (after 2 digits) and again during HOLD -> all outputs 0 immediately; a subsequent seg_valid without frame_start is ignored.
6. Sweep all 128 patterns through one frame each (NUM_DIGITS=1) -> the 10 legal patterns decode per table with out_err=0; the other 118 give 4'hF with out_err=1.
